// File: rtl/kb_scan_ctrl_if.sv
// Byte-in / key-state-out bundle between the kb receiver and kb_scan_ctrl.
// master: the receiver side that drives bytes. slave: the scan controller.
interface kb_scan_ctrl_if;
  // Handshake: rx_done_tick is a one-cycle valid strobe with no ready.
  // rx_data is meaningful only in a cycle where rx_done_tick=1, and the
  // controller accepts every byte.
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic [4:0] p1;
  logic [4:0] p2;
  logic       p1_fire;
  logic       p2_fire;
  logic       seq_err;
  logic [2:0] state;

  modport master (
    output rx_data, rx_done_tick,
    input  p1, p2, p1_fire, p2_fire, seq_err, state
  );

  modport slave (
    input  rx_data, rx_done_tick,
    output p1, p2, p1_fire, p2_fire, seq_err, state
  );
endinterface

// File: rtl/kb_scan_ctrl.sv
// PS/2 scan-code sequencer: decodes prefix sequences into per-player held-key
// vectors, with rate-limited fire strobes and a stalled-prefix watchdog.
module kb_scan_ctrl #(
  parameter int REQUIRE_EXT = 1,
  parameter int CD_W        = 24,
  parameter int COOLDOWN    = 5000000,
  parameter int TO_W        = 16,
  parameter int PREFIX_TO   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  kb_scan_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXT     = 3'd1;
  localparam logic [2:0] BRK     = 3'd2;
  localparam logic [2:0] EXT_BRK = 3'd3;
  localparam logic [2:0] PAUSE   = 3'd4;

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TO - 1);

  logic [7:0]      byte_q;
  logic            tick_q;
  logic [2:0]      state;
  logic [2:0]      state_n;
  logic [2:0]      skip;
  logic [2:0]      skip_n;
  logic [4:0]      p1_r;
  logic [4:0]      p2_r;
  logic [4:0]      p1_n;
  logic [4:0]      p2_n;
  logic            p1_fire_r;
  logic            p2_fire_r;
  logic            seq_err_r;
  logic            err_n;
  logic            ev_make;
  logic            ev_brk;
  logic            ev_ext;
  logic            clear;
  logic            wd_expire;
  logic            fire1;
  logic            fire2;
  logic [9:0]      mask;
  logic [CD_W-1:0] cd1;
  logic [CD_W-1:0] cd2;
  logic [TO_W-1:0] wd;

  // Returns {p2_mask, p1_mask} for a code; all-zero means unmapped.
  function automatic logic [9:0] key_map(input logic [7:0] code, input logic ext);
    logic [9:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        8'h1D:   m[0] = 1'b1;
        8'h1B:   m[1] = 1'b1;
        8'h1C:   m[2] = 1'b1;
        8'h23:   m[3] = 1'b1;
        8'h3B:   m[4] = 1'b1;
        8'h4C:   m[9] = 1'b1;
        default: m = m;
      endcase
    end
    if (ext || (REQUIRE_EXT == 0)) begin
      case (code)
        8'h75:   m[5] = 1'b1;
        8'h72:   m[6] = 1'b1;
        8'h6B:   m[7] = 1'b1;
        8'h74:   m[8] = 1'b1;
        default: m = m;
      endcase
    end
    return m;
  endfunction

  // Input register: the byte is decoded one edge after it is sampled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_q <= 8'h00;
      tick_q <= 1'b0;
    end else begin
      byte_q <= bus.rx_data;
      tick_q <= bus.rx_done_tick;
    end
  end

  assign wd_expire = (state != IDLE) && (wd == TO_LAST);

  always_comb begin
    state_n = state;
    skip_n  = skip;
    err_n   = 1'b0;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    clear   = 1'b0;
    if (tick_q) begin
      if (byte_q == 8'h00 || byte_q == 8'hFF) begin
        clear   = 1'b1;
        err_n   = 1'b1;
        state_n = IDLE;
      end else begin
        case (state)
          IDLE: begin
            case (byte_q)
              8'hF0:        state_n = BRK;
              8'hE0:        state_n = EXT;
              8'hE1: begin
                state_n = PAUSE;
                skip_n  = 3'd7;
              end
              8'hAA:        clear = 1'b1;
              8'hFA, 8'hFE: clear = 1'b0;
              default:      ev_make = 1'b1;
            endcase
          end
          EXT: begin
            if (byte_q == 8'hF0) begin
              state_n = EXT_BRK;
            end else if (byte_q != 8'hE0) begin
              ev_make = 1'b1;
              ev_ext  = 1'b1;
              state_n = IDLE;
            end
          end
          BRK, EXT_BRK: begin
            if (byte_q == 8'hE0 || byte_q == 8'hF0) begin
              err_n = 1'b1;
            end else begin
              ev_brk = 1'b1;
              ev_ext = (state == EXT_BRK);
            end
            state_n = IDLE;
          end
          PAUSE: begin
            // Pause bytes are swallowed whole, including embedded E1/F0.
            skip_n = skip - 3'd1;
            if (skip <= 3'd1) state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end else if (wd_expire) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end

  assign mask = key_map(byte_q, ev_ext);

  always_comb begin
    p1_n = p1_r;
    p2_n = p2_r;
    if (clear) begin
      p1_n = '0;
      p2_n = '0;
    end else if (ev_make) begin
      p1_n = p1_r | mask[4:0];
      p2_n = p2_r | mask[9:5];
    end else if (ev_brk) begin
      p1_n = p1_r & ~mask[4:0];
      p2_n = p2_r & ~mask[9:5];
    end
  end

  // Fire only on a 0->1 shoot edge; repeats and cooled-down makes are silent.
  assign fire1 = ev_make && mask[4] && !p1_r[4] && (cd1 == '0);
  assign fire2 = ev_make && mask[9] && !p2_r[4] && (cd2 == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      skip      <= 3'd0;
      p1_r      <= '0;
      p2_r      <= '0;
      p1_fire_r <= 1'b0;
      p2_fire_r <= 1'b0;
      seq_err_r <= 1'b0;
      cd1       <= '0;
      cd2       <= '0;
      wd        <= '0;
    end else begin
      state     <= state_n;
      skip      <= skip_n;
      p1_r      <= p1_n;
      p2_r      <= p2_n;
      p1_fire_r <= fire1;
      p2_fire_r <= fire2;
      seq_err_r <= err_n;
      if (fire1)            cd1 <= CD_LOAD;
      else if (cd1 != '0)   cd1 <= cd1 - 1'b1;
      if (fire2)            cd2 <= CD_LOAD;
      else if (cd2 != '0)   cd2 <= cd2 - 1'b1;
      if (tick_q || state == IDLE || wd_expire) wd <= '0;
      else                                      wd <= wd + 1'b1;
    end
  end

  assign bus.p1      = p1_r;
  assign bus.p2      = p2_r;
  assign bus.p1_fire = p1_fire_r;
  assign bus.p2_fire = p2_fire_r;
  assign bus.seq_err = seq_err_r;
  assign bus.state   = state;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed byte streams with hand-computed responses, checked by a monitor
// that pops the expected queue two edges after each byte strobe.
module tb_kb_scan_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXT  = 3'd1;
  localparam logic [2:0] S_BRK  = 3'd2;
  localparam logic [2:0] S_EBRK = 3'd3;
  localparam logic [2:0] S_PAUS = 3'd4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  kb_scan_ctrl_if bus();
  kb_scan_ctrl_if bus0();

  kb_scan_ctrl #(.REQUIRE_EXT(1), .CD_W(24), .COOLDOWN(20), .TO_W(16), .PREFIX_TO(10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  kb_scan_ctrl #(.REQUIRE_EXT(0), .CD_W(24), .COOLDOWN(20), .TO_W(16), .PREFIX_TO(10)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  logic [W-1:0] exp_q[$];
  logic [7:0]   tag_q[$];
  int           wd_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         t_d1 = 1'b0;
  logic         t_d2 = 1'b0;

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    t_d1 <= bus.rx_done_tick;
    t_d2 <= t_d1;
  end

  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic [7:0]   tag;
    got = {bus.p1, bus.p2, bus.p1_fire, bus.p2_fire, bus.seq_err, bus.state};
    if (t_d2) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte_resp no expectation queued, got %h", got);
      end else begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL byte_%h got p1=%b p2=%b f1=%b f2=%b err=%b st=%0d exp p1=%b p2=%b f1=%b f2=%b err=%b st=%0d",
                   tag, got[15:11], got[10:6], got[5], got[4], got[3], got[2:0],
                   exp[15:11], exp[10:6], exp[5], exp[4], exp[3], exp[2:0]);
        end
      end
    end else begin
      if (bus.seq_err) begin
        checks++;
        if (wd_q.size() == 0 || bus.state !== S_IDLE) begin
          errors++;
          $display("FAIL watchdog_err got seq_err=1 st=%0d exp no pulse or st=0 (pending=%0d)",
                   bus.state, wd_q.size());
        end else begin
          void'(wd_q.pop_front());
        end
      end
      if (bus.p1_fire || bus.p2_fire) begin
        checks++;
        errors++;
        $display("FAIL stray_fire got f1=%b f2=%b exp 0 0", bus.p1_fire, bus.p2_fire);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge gap cycles later.
  task automatic send(input logic [7:0] b, input logic [4:0] ep1, input logic [4:0] ep2,
                      input logic ef1, input logic ef2, input logic eerr,
                      input logic [2:0] est, input int gap);
    exp_q.push_back({ep1, ep2, ef1, ef2, eerr, est});
    tag_q.push_back(b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic sd(input logic [7:0] b, input logic [4:0] ep1, input logic [4:0] ep2,
                    input logic ef1, input logic ef2, input logic eerr, input logic [2:0] est);
    send(b, ep1, ep2, ef1, ef2, eerr, est, 5);
  endtask

  task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.rx_data       = 8'h00;
    bus.rx_done_tick  = 1'b0;
    bus0.rx_data      = 8'h00;
    bus0.rx_done_tick = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_state", {bus.p1, bus.p2, bus.p1_fire, bus.p2_fire, bus.seq_err, bus.state}, '0);
    reset = 1'b1;
    @(negedge clk);

    // Bare 75 on the REQUIRE_EXT=0 instance acts as P2 up.
    bus0.rx_data      = 8'h75;
    bus0.rx_done_tick = 1'b1;
    @(negedge clk);
    bus0.rx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_val("noext_75", {11'd0, bus0.p2}, {11'd0, 5'b00001});

    // Make / break
    sd(8'h1D, 5'b00001, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hF0, 5'b00001, 5'b00000, 0, 0, 0, S_BRK);
    sd(8'h1D, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    // Extended arrows
    sd(8'h75, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hE0, 5'b00000, 5'b00000, 0, 0, 0, S_EXT);
    sd(8'h75, 5'b00000, 5'b00001, 0, 0, 0, S_IDLE);
    sd(8'hE0, 5'b00000, 5'b00001, 0, 0, 0, S_EXT);
    sd(8'hF0, 5'b00000, 5'b00001, 0, 0, 0, S_EBRK);
    sd(8'h75, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    // Fire cooldown (20 cycles)
    sd(8'h3B, 5'b10000, 5'b00000, 1, 0, 0, S_IDLE);
    sd(8'hF0, 5'b10000, 5'b00000, 0, 0, 0, S_BRK);
    sd(8'h3B, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'h3B, 5'b10000, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'h3B, 5'b10000, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hF0, 5'b10000, 5'b00000, 0, 0, 0, S_BRK);
    send(8'h3B, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE, 25);
    sd(8'h3B, 5'b10000, 5'b00000, 1, 0, 0, S_IDLE);
    sd(8'h3B, 5'b10000, 5'b00000, 0, 0, 0, S_IDLE);
    // Independent P1/P2 cooldowns, consecutive ticks
    sd(8'hF0, 5'b10000, 5'b00000, 0, 0, 0, S_BRK);
    send(8'h3B, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE, 25);
    send(8'h4C, 5'b00000, 5'b10000, 0, 1, 0, S_IDLE, 1);
    sd(8'h3B, 5'b10000, 5'b10000, 1, 0, 0, S_IDLE);
    sd(8'hF0, 5'b10000, 5'b10000, 0, 0, 0, S_BRK);
    sd(8'h4C, 5'b10000, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hF0, 5'b10000, 5'b00000, 0, 0, 0, S_BRK);
    sd(8'h3B, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    // Pause sequence while P1 up held
    sd(8'h1D, 5'b00001, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hE1, 5'b00001, 5'b00000, 0, 0, 0, S_PAUS);
    sd(8'h14, 5'b00001, 5'b00000, 0, 0, 0, S_PAUS);
    sd(8'h77, 5'b00001, 5'b00000, 0, 0, 0, S_PAUS);
    sd(8'hE1, 5'b00001, 5'b00000, 0, 0, 0, S_PAUS);
    sd(8'hF0, 5'b00001, 5'b00000, 0, 0, 0, S_PAUS);
    sd(8'h14, 5'b00001, 5'b00000, 0, 0, 0, S_PAUS);
    sd(8'hF0, 5'b00001, 5'b00000, 0, 0, 0, S_PAUS);
    sd(8'h77, 5'b00001, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hF0, 5'b00001, 5'b00000, 0, 0, 0, S_BRK);
    sd(8'h1D, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    // Watchdog abandons a stalled E0
    wd_q.push_back(1);
    send(8'hE0, 5'b00000, 5'b00000, 0, 0, 0, S_EXT, 16);
    check_val("watchdog_fired", 16'(wd_q.size()), 16'd0);
    sd(8'h75, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    // Overrun, BAT and malformed break prefixes
    sd(8'h1D, 5'b00001, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hE0, 5'b00001, 5'b00000, 0, 0, 0, S_EXT);
    sd(8'h74, 5'b00001, 5'b01000, 0, 0, 0, S_IDLE);
    sd(8'hFF, 5'b00000, 5'b00000, 0, 0, 1, S_IDLE);
    sd(8'h1C, 5'b00100, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hE0, 5'b00100, 5'b00000, 0, 0, 0, S_EXT);
    sd(8'h72, 5'b00100, 5'b00010, 0, 0, 0, S_IDLE);
    sd(8'hAA, 5'b00000, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hF0, 5'b00000, 5'b00000, 0, 0, 0, S_BRK);
    sd(8'hE0, 5'b00000, 5'b00000, 0, 0, 1, S_IDLE);
    sd(8'hE0, 5'b00000, 5'b00000, 0, 0, 0, S_EXT);
    sd(8'hF0, 5'b00000, 5'b00000, 0, 0, 0, S_EBRK);
    sd(8'hF0, 5'b00000, 5'b00000, 0, 0, 1, S_IDLE);
    sd(8'h1D, 5'b00001, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hE0, 5'b00001, 5'b00000, 0, 0, 0, S_EXT);
    sd(8'h00, 5'b00000, 5'b00000, 0, 0, 1, S_IDLE);
    // Reset between F0 and 1D
    sd(8'h1B, 5'b00010, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hF0, 5'b00010, 5'b00000, 0, 0, 0, S_BRK);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid_reset", {bus.p1, bus.p2, bus.p1_fire, bus.p2_fire, bus.seq_err, bus.state}, '0);
    reset = 1'b1;
    @(negedge clk);
    sd(8'h1D, 5'b00001, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hFA, 5'b00001, 5'b00000, 0, 0, 0, S_IDLE);
    sd(8'hE0, 5'b00001, 5'b00000, 0, 0, 0, S_EXT);
    sd(8'hE0, 5'b00001, 5'b00000, 0, 0, 0, S_EXT);
    sd(8'h6B, 5'b00001, 5'b00100, 0, 0, 0, S_IDLE);

    repeat (5) @(negedge clk);
    check_val("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kb_scan_ctrl.md
Name: kb_scan_ctrl

Overview:
- Sequences the raw PS/2 byte stream from the kb receiver into per-player key-state vectors for the game core.
- Handles the 0xE0 (extended), 0xF0 (break) and 0xE1 (Pause) prefix sequences, keyboard BAT (0xAA) and overrun (0x00/0xFF) codes, and a stalled-prefix watchdog.
- Produces rate-limited one-cycle fire strobes per player.
- Sits between the kb receiver and the game logic, in the kb receiver's clock domain.

Parameters:
- REQUIRE_EXT, 1, 1: arrow codes 75/72/6B/74 match P2 only when E0-prefixed; 0: match with or without E0.
- CD_W, 24, width of the fire cooldown counters.
- COOLDOWN, 5000000, cycles between permitted fire strobes per player (100 ms at 50 MHz).
- TO_W, 16, width of the prefix watchdog counter.
- PREFIX_TO, 50000, cycles without a byte before a pending prefix is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low
- rx_data  in  8  received byte; valid when rx_done_tick=1
- rx_done_tick  in  1  one-cycle strobe, new byte on rx_data
- p1  out  5  P1 held keys, bit 0..4 = up, down, left, right, shoot
- p2  out  5  P2 held keys, same bit order
- p1_fire  out  1  one-cycle P1 fire strobe
- p2_fire  out  1  one-cycle P2 fire strobe
- seq_err  out  1  one-cycle strobe on a discarded or abandoned sequence

Behaviour:
- Reset (reset=0 at a clk edge):
  - p1=p2=0, fire strobes=0, seq_err=0.
  - FSM=IDLE, cooldown counters=0, watchdog=0.
- Key map, non-extended:
  - P1: 1D=up, 1B=down, 1C=left, 23=right, 3B=shoot.
  - P2: 4C=shoot.
- Key map, extended (E0-prefixed):
  - P2: 75=up, 72=down, 6B=left, 74=right.
  - Any other extended code is ignored.
- A make event sets the mapped bit; a break event clears it. Unmapped codes change nothing.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions on rx_done_tick only:
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - E1 -> PAUSE, skip counter=7.
    - AA -> clear p1/p2, stay IDLE.
    - FA/FE -> ignore.
    - Any other byte -> make(code, ext=0).
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> EXT.
    - Any other byte -> make(code, ext=1), then IDLE.
  - BRK:
    - E0/F0 -> seq_err, then IDLE.
    - Any other byte -> break(code, ext=0), then IDLE.
  - EXT_BRK:
    - E0/F0 -> seq_err, then IDLE.
    - Any other byte -> break(code, ext=1), then IDLE.
  - PAUSE: each byte decrements the skip counter; at 0 -> IDLE. No key effect.
- Overrides, in any state:
  - Byte 00 or FF: clear p1/p2, pulse seq_err, go to IDLE. Has priority over all other rules.
- Watchdog:
  - Counts cycles while FSM != IDLE; reset to 0 on every rx_done_tick.
  - On reaching PREFIX_TO-1: FSM -> IDLE, seq_err pulses. Key state is unchanged.
- Latency: p1/p2 update on the clk edge after the one sampling the completing rx_done_tick (one registered stage).
- Fire strobes:
  - pX_fire=1 for exactly one cycle, on the same edge that sets shoot bit 4 from 0 to 1, provided cooldownX==0.
  - On that edge cooldownX loads COOLDOWN-1, then decrements by 1 each clk down to 0 (saturates at 0).
  - Typematic repeats (make while already held) never fire.
  - A make that arrives during cooldown sets the bit but does not fire; no deferred fire.
  - P1 and P2 cooldowns are independent.
- Simultaneous events: one byte per tick, so at most one key event per cycle. A watchdog expiry coinciding with rx_done_tick loses; the byte is processed normally.
- Reset mid-sequence: pending prefix discarded; first byte after reset is decoded in IDLE.

Test Plan:
- Byte stream 1D, F0 1D -> p1=00001 one cycle after the first tick, p1=00000 after the second break byte; seq_err stays 0.
- REQUIRE_EXT=1: 75 -> p2 unchanged. E0 75 -> p2[0]=1. E0 F0 75 -> p2[0]=0. With REQUIRE_EXT=0, bare 75 -> p2[0]=1.
- COOLDOWN=20: 3B, F0 3B, 3B at 5-cycle spacing -> exactly one p1_fire, on the first make. Same pair after 25 cycles -> second p1_fire. 3B repeated while held -> no fire.
- 4C and 3B on consecutive ticks -> p2_fire and p1_fire each pulse once, cycles apart; cooldowns independent.
- Pause sequence E1 14 77 E1 F0 14 F0 77 while P1 up held -> p1 stays 00001, no seq_err. Following F0 1D -> p1=0.
- PREFIX_TO=10: E0 then 12 idle cycles -> seq_err pulse, FSM back to IDLE. Then 75 with REQUIRE_EXT=1 -> ignored.
- Held keys then byte FF, or AA -> p1=p2=0. Reset (reset=0) asserted between F0 and 1D -> 1D after release is treated as make.
